data_memory_controller: RTL and testbench

Sequential data-memory responder for the single-cycle RISC-V core. It executes the load/store requests that the main decoder's 4-bit `memory_control` field initiates, against an internal word-wide synchronous RAM. It handles byte, half and word sizes, little-endian lane placement, and sign/zero extension. Misaligned accesses are split into two word accesses. The core stalls on `busy` and consumes `read_data` on `done`.

---
 rtl/data_memory_controller.sv | 177 +++++++++++++++++
 tb/tb_data_memory_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_controller.sv
// Load/store responder for the RISC-V core: byte/half/word accesses against a
// lane-split synchronous RAM, with misaligned requests split over two words.

module dmc_lane_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);
  logic [7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

module data_memory_controller #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  memory_control,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCESS0, ACCESS1, COMPLETE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            ctl_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic [31:0]           lo_q;

  // Request legality on the raw inputs; the last touched byte must stay in range
  logic [2:0]  req_span;
  logic [32:0] req_last;
  logic        req_illegal;
  logic        accept;

  always_comb begin
    req_span = 3'd0;
    case (memory_control[2:1])
      2'b00:   req_span = 3'd3;
      2'b01:   req_span = 3'd1;
      default: req_span = 3'd0;
    endcase
  end

  assign req_last    = {1'b0, address} + {30'b0, req_span};
  assign req_illegal = (memory_control[2:1] == 2'b11) ||
                       ((req_last >> (ADDR_WIDTH + 2)) != 33'd0);
  assign accept      = (state == IDLE) && start && !done;

  // Latched request decode
  logic [1:0]            off;
  logic [ADDR_WIDTH-1:0] widx;
  logic [4:0]            sh;
  logic [3:0]            size_mask;
  logic [7:0]            lane_mask;
  logic [63:0]           st_data;
  logic                  split;

  assign off  = addr_q[1:0];
  assign widx = addr_q[ADDR_WIDTH+1:2];
  assign sh   = {off, 3'b000};

  always_comb begin
    size_mask = 4'h1;
    case (ctl_q[2:1])
      2'b00:   size_mask = 4'hF;
      2'b01:   size_mask = 4'h3;
      default: size_mask = 4'h1;
    endcase
  end

  assign lane_mask = {4'b0000, size_mask} << off;
  assign st_data   = {32'b0, wdata_q} << sh;
  assign split     = |lane_mask[7:4];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = req_illegal ? COMPLETE : ACCESS0;
      ACCESS0:  state_nxt = split ? ACCESS1 : COMPLETE;
      ACCESS1:  state_nxt = COMPLETE;
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // RAM lanes; write enables are cut by reset so a pending second word is dropped
  logic [ADDR_WIDTH-1:0]           ram_addr;
  logic [NUM_LANES-1:0]            ram_we;
  logic [NUM_LANES-1:0][7:0]       ram_wdata;
  logic [NUM_LANES-1:0][7:0]       ram_rdata;

  always_comb begin
    ram_addr  = (state == ACCESS1) ? widx + ADDR_WIDTH'(1) : widx;
    ram_wdata = (state == ACCESS1) ? st_data[63:32] : st_data[31:0];
    ram_we    = '0;
    if (!reset && ctl_q[0]) begin
      if (state == ACCESS0)      ram_we = lane_mask[3:0];
      else if (state == ACCESS1) ram_we = lane_mask[7:4];
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dmc_lane_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clock (clock),
      .we    (ram_we[g]),
      .addr  (ram_addr),
      .wdata (ram_wdata[g]),
      .rdata (ram_rdata[g])
    );
  end

  // Load assembly: in COMPLETE the RAM output holds word w (aligned) or w+1 (split)
  logic [63:0] ld_cat;
  logic [31:0] ld_word;
  logic [31:0] ld_ext;

  assign ld_cat  = split ? {ram_rdata, lo_q} : {32'b0, ram_rdata};
  assign ld_word = 32'(ld_cat >> sh);

  always_comb begin
    ld_ext = ld_word;
    case (ctl_q[2:1])
      2'b01:   ld_ext = {{16{~ctl_q[3] & ld_word[15]}}, ld_word[15:0]};
      2'b10:   ld_ext = {{24{~ctl_q[3] & ld_word[7]}}, ld_word[7:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      error     <= 1'b0;
      read_data <= '0;
      ctl_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      lo_q      <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == COMPLETE);
      if (accept) begin
        ctl_q   <= memory_control;
        addr_q  <= address[ADDR_WIDTH+1:0];
        wdata_q <= write_data;
        err_q   <= req_illegal;
        error   <= 1'b0;
      end
      if (state == ACCESS1) lo_q <= ram_rdata;
      if (state == COMPLETE) begin
        error <= err_q;
        if (err_q)          read_data <= '0;
        else if (!ctl_q[0]) read_data <= ld_ext;
      end
    end
  end

  assign busy = (state != IDLE) || done;
endmodule

// File: tb/tb_data_memory_controller.sv
// Scoreboard bench for data_memory_controller: a byte-array model predicts each
// response, observed responses are queued and compared per scenario.

module tb_data_memory_controller;
  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  memory_control;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busy;
  logic        done;
  logic        error;

  data_memory_controller #(.ADDR_WIDTH(10)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .memory_control (memory_control),
    .address        (address),
    .write_data     (write_data),
    .read_data      (read_data),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [3:0] LW = 4'b0000, SW = 4'b0001, LH = 4'b0010, SH = 4'b0011;
  localparam logic [3:0] LB = 4'b0100, SB = 4'b0101, LHU = 4'b1010, LBU = 4'b1100;
  localparam logic [3:0] BAD = 4'b0110;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          bc;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];

  logic [7:0]  mem_m [0:4095];
  logic [31:0] last_rd;
  int          total;
  int          passed;

  function automatic int nbytes(input logic [3:0] c);
    case (c[2:1])
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  // Drive one request and record what the DUT returns; bounded wait for done
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                       output rsp_t o);
    o.name = "";
    o.rd   = 32'h0;
    o.er   = 1'b0;
    o.lat  = -1;
    o.bc   = 0;
    @(negedge clock);
    start          = 1'b1;
    memory_control = c;
    address        = a;
    write_data     = wd;
    @(posedge clock);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clock);
      if (busy) o.bc++;
      if (done) begin
        o.rd  = read_data;
        o.er  = error;
        o.lat = cyc - 1;
        break;
      end
    end
  endtask

  // Model the request, push its expectation, then run it on the DUT
  task automatic req(input string name, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] wd);
    rsp_t        e;
    rsp_t        o;
    int          n;
    logic [31:0] v;
    n      = nbytes(c);
    e.name = name;
    if (n == 0 || a > 32'hFFF || (longint'(a) + n - 1) > 4095) begin
      e.er  = 1'b1;
      e.rd  = 32'h0;
      e.lat = 1;
    end else begin
      e.er  = 1'b0;
      e.lat = ((a % 4) + n > 4) ? 3 : 2;
      if (c[0]) begin
        for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
        e.rd = last_rd;
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[a + i];
        if (!c[3]) begin
          if (n == 1)      v = {{24{v[7]}}, v[7:0]};
          else if (n == 2) v = {{16{v[15]}}, v[15:0]};
        end
        e.rd = v;
      end
    end
    e.bc    = e.lat + 1;
    last_rd = e.rd;
    exp_q.push_back(e);
    issue(c, a, wd, o);
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    memory_control = 4'h0;
    address = 32'h0;
    write_data = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (error !== 1'b0) $display("FAIL reset_error got %b want 0", error); else passed++;
    total++; if (read_data !== 32'h0) $display("FAIL reset_read_data got %h want 0", read_data);
             else passed++;
    reset   = 1'b0;
    last_rd = 32'h0;
  endtask

  task automatic test_aligned_word();
    rsp_t e, o;
    req("sw_10", SW, 32'h10, 32'hDEADBEEF);
    req("lw_10", LW, 32'h10, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.rd !== e.rd) $display("FAIL %s rd got %h want %h", e.name, o.rd, e.rd); else passed++;
      total++; if (o.er !== e.er) $display("FAIL %s err got %b want %b", e.name, o.er, e.er); else passed++;
      total++; if (o.lat != e.lat) $display("FAIL %s lat got %0d want %0d", e.name, o.lat, e.lat); else passed++;
      total++; if (o.bc != e.bc) $display("FAIL %s busy got %0d want %0d", e.name, o.bc, e.bc); else passed++;
    end
  endtask

  task automatic test_byte_lanes();
    rsp_t e, o;
    req("sw_20", SW, 32'h20, 32'h01020304);
    req("sb_21", SB, 32'h21, 32'hFFFFFF80);
    req("sb_22", SB, 32'h22, 32'h1234567F);
    req("lb_21", LB, 32'h21, 32'h0);
    req("lbu_21", LBU, 32'h21, 32'h0);
    req("lb_22", LB, 32'h22, 32'h0);
    req("lw_20", LW, 32'h20, 32'h0);
    req("lh_22", LH, 32'h22, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.rd !== e.rd) $display("FAIL %s rd got %h want %h", e.name, o.rd, e.rd); else passed++;
      total++; if (o.er !== e.er) $display("FAIL %s err got %b want %b", e.name, o.er, e.er); else passed++;
      total++; if (o.lat != e.lat) $display("FAIL %s lat got %0d want %0d", e.name, o.lat, e.lat); else passed++;
      total++; if (o.bc != e.bc) $display("FAIL %s busy got %0d want %0d", e.name, o.bc, e.bc); else passed++;
    end
  endtask

  task automatic test_split();
    rsp_t e, o;
    req("sw_08", SW, 32'h08, 32'h55667788);
    req("sw_0c", SW, 32'h0C, 32'h99AABBCC);
    req("sh_0b", SH, 32'h0B, 32'h0000A5C3);
    req("lh_0b", LH, 32'h0B, 32'h0);
    req("lhu_0b", LHU, 32'h0B, 32'h0);
    req("lw_08", LW, 32'h08, 32'h0);
    req("lw_0c", LW, 32'h0C, 32'h0);
    req("sw_04", SW, 32'h04, 32'hCAFEF00D);
    req("sw_08b", SW, 32'h08, 32'h0BADBEEF);
    req("sw_06", SW, 32'h06, 32'h11223344);
    req("lw_06", LW, 32'h06, 32'h0);
    req("lw_04", LW, 32'h04, 32'h0);
    req("lw_08c", LW, 32'h08, 32'h0);
    req("lw_07", LW, 32'h07, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.rd !== e.rd) $display("FAIL %s rd got %h want %h", e.name, o.rd, e.rd); else passed++;
      total++; if (o.er !== e.er) $display("FAIL %s err got %b want %b", e.name, o.er, e.er); else passed++;
      total++; if (o.lat != e.lat) $display("FAIL %s lat got %0d want %0d", e.name, o.lat, e.lat); else passed++;
      total++; if (o.bc != e.bc) $display("FAIL %s busy got %0d want %0d", e.name, o.bc, e.bc); else passed++;
    end
  endtask

  task automatic test_errors();
    rsp_t e, o;
    req("sw_ffc", SW, 32'hFFC, 32'hA1B2C3D4);
    req("lw_ffc", LW, 32'hFFC, 32'h0);
    req("lw_1000", LW, 32'h1000, 32'h0);
    req("lw_ffe", LW, 32'hFFE, 32'h0);
    req("bad_size", BAD, 32'h10, 32'h0);
    req("sw_ffe", SW, 32'hFFE, 32'h12345678);
    req("lw_ffc2", LW, 32'hFFC, 32'h0);
    req("lhu_ffe", LHU, 32'hFFE, 32'h0);
    req("lb_fff", LB, 32'hFFF, 32'h0);
    req("lh_fff", LH, 32'hFFF, 32'h0);
    req("lw_far", LW, 32'h8000_0010, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.rd !== e.rd) $display("FAIL %s rd got %h want %h", e.name, o.rd, e.rd); else passed++;
      total++; if (o.er !== e.er) $display("FAIL %s err got %b want %b", e.name, o.er, e.er); else passed++;
      total++; if (o.lat != e.lat) $display("FAIL %s lat got %0d want %0d", e.name, o.lat, e.lat); else passed++;
      total++; if (o.bc != e.bc) $display("FAIL %s busy got %0d want %0d", e.name, o.bc, e.bc); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    rsp_t        e, o;
    logic [3:0]  ops [8];
    logic [3:0]  c;
    logic [31:0] a;
    ops = '{LW, SW, LH, LHU, SH, LB, LBU, SB};
    for (int i = 0; i < 16; i++)
      req($sformatf("fill_%0d", i), SW, 32'h100 + 4*i, $urandom);
    for (int i = 0; i < 24; i++) begin
      c = ops[$urandom_range(0, 7)];
      a = 32'h100 + $urandom_range(0, 59);
      req($sformatf("rnd_%0d_%h_%h", i, c, a), c, a, $urandom);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.rd !== e.rd) $display("FAIL %s rd got %h want %h", e.name, o.rd, e.rd); else passed++;
      total++; if (o.er !== e.er) $display("FAIL %s err got %b want %b", e.name, o.er, e.er); else passed++;
      total++; if (o.lat != e.lat) $display("FAIL %s lat got %0d want %0d", e.name, o.lat, e.lat); else passed++;
      total++; if (o.bc != e.bc) $display("FAIL %s busy got %0d want %0d", e.name, o.bc, e.bc); else passed++;
    end
  endtask

  task automatic test_reset_midop();
    rsp_t e, o;
    req("pre_08", SW, 32'h08, 32'h11111111);
    req("pre_0c", SW, 32'h0C, 32'h22222222);
    @(negedge clock);
    start          = 1'b1;
    memory_control = SH;
    address        = 32'h0B;
    write_data     = 32'h0000A5C3;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    total++; if (busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL midreset_done got %b want 0", done); else passed++;
    reset        = 1'b0;
    mem_m[12'hB] = 8'hC3;
    last_rd      = 32'h0;
    req("post_08", LW, 32'h08, 32'h0);
    req("post_0c", LW, 32'h0C, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.rd !== e.rd) $display("FAIL %s rd got %h want %h", e.name, o.rd, e.rd); else passed++;
      total++; if (o.er !== e.er) $display("FAIL %s err got %b want %b", e.name, o.er, e.er); else passed++;
      total++; if (o.lat != e.lat) $display("FAIL %s lat got %0d want %0d", e.name, o.lat, e.lat); else passed++;
      total++; if (o.bc != e.bc) $display("FAIL %s busy got %0d want %0d", e.name, o.bc, e.bc); else passed++;
    end
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    last_rd = 32'h0;
    for (int i = 0; i < 4096; i++) mem_m[i] = 8'h00;
    test_reset();
    test_aligned_word();
    test_byte_lanes();
    test_split();
    test_errors();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end
endmodule
